pdp8_ide_target: RTL and testbench

- Synthesizable ATA/IDE device-side responder: the target end of the IDE bus that the pdp8_io disk controller drives.
- Decodes host register cycles and holds the task file and status register.
- Runs READ SECTOR(S) and WRITE SECTOR(S) PIO transfers through a 256-word sector buffer.
- Backs sectors onto a simple request/done memory port. Used as an on-chip disk for FPGA builds and as the disk in system simulation.

---
 rtl/pdp8_ide_pkg.sv | 52 +++++
 rtl/ide_sector_buf.sv | 24 ++
 rtl/pdp8_ide_target.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_pdp8_ide_target.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_ide_pkg.sv
// Shared constants and types for the IDE device-side responder.
// Register map, opcodes, status/error bits and the transfer FSM states.
package pdp8_ide_pkg;

  localparam logic [1:0] CS_CMD = 2'b10;
  localparam logic [1:0] CS_CTL = 2'b01;

  localparam logic [2:0] DA_DATA   = 3'd0;
  localparam logic [2:0] DA_ERR    = 3'd1;
  localparam logic [2:0] DA_COUNT  = 3'd2;
  localparam logic [2:0] DA_LBA0   = 3'd3;
  localparam logic [2:0] DA_LBA1   = 3'd4;
  localparam logic [2:0] DA_LBA2   = 3'd5;
  localparam logic [2:0] DA_DH     = 3'd6;
  localparam logic [2:0] DA_CMD    = 3'd7;
  localparam logic [2:0] DA_DEVCTL = 3'd6;

  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_WRITE = 8'h30;
  localparam logic [7:0] CMD_IDENT = 8'hEC;
  localparam logic [7:0] CMD_INITP = 8'h91;
  localparam logic [7:0] CMD_RECAL = 8'h10;

  localparam int ST_BSY  = 7;
  localparam int ST_DRDY = 6;
  localparam int ST_DSC  = 4;
  localparam int ST_DRQ  = 3;
  localparam int ST_ERR  = 0;

  localparam int DC_NIEN = 1;
  localparam int DC_SRST = 2;

  localparam logic [7:0] ERR_ABRT = 8'h04;
  localparam logic [7:0] ERR_IDNF = 8'h10;

  typedef enum logic [2:0] {
    IDLE,
    RD_FETCH,
    RD_XFER,
    WR_XFER,
    WR_FLUSH
  } ide_state_t;

  // True when no LBA bit above the implemented width is set.
  function automatic logic lba_in_range(
    input logic [27:0] lba,
    input int          bits
  );
    return (lba >> bits) == 28'd0;
  endfunction

endpackage

// File: rtl/ide_sector_buf.sv
// 256x16 sector buffer: one write port, one registered read port.
// Shaped so synthesis maps it onto a single block RAM.
module ide_sector_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [7:0]  raddr,
  output logic [15:0] rdata
);

  logic [15:0] mem [256];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pdp8_ide_target.sv
// IDE device responder: task file, status, PIO sector transfers
// through a sector buffer backed by a request/done memory port.
module pdp8_ide_target
  import pdp8_ide_pkg::*;
#(
  parameter int LBA_BITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ide_dior,
  input  logic                  ide_diow,
  input  logic [1:0]            ide_cs,
  input  logic [2:0]            ide_da,
  input  logic [15:0]           ide_data_in,
  output logic [15:0]           ide_data_out,
  output logic                  ide_data_oe,
  output logic                  ide_intrq,
  output logic [LBA_BITS+7:0]   mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_done
);

  localparam int SW = 23;
  localparam logic [SW-1:0] SYNC_RST = {4'b1111, 19'd0};

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] s;
  logic        s_dior, s_diow;
  logic [1:0]  s_cs;
  logic [2:0]  s_da;
  logic [15:0] s_data;
  logic        dior_q, diow_q;
  logic        wr_ev, rd_end, sel_cmd, sel_ctl;

  ide_state_t  state, state_n;
  logic [7:0]  ptr, ptr_n, count, count_n;
  logic [7:0]  error, error_n;
  logic [27:0] lba, lba_n, lba_inc;
  logic        err, err_n, bsy, bsy_n, drq, drq_n;
  logic        intrq, intrq_n, nien, nien_n;
  logic        srst, srst_n, req, req_n, idnf;
  logic        buf_we;
  logic [15:0] buf_wdata, buf_rdata;
  logic [7:0]  status;
  logic        rd_sel_cmd, rd_sel_ctl;
  logic [15:0] rd_val;

  // Host strobes, selects and data cross into clk through a flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {ide_dior, ide_diow, ide_cs, ide_da, ide_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign s_dior = s[22];
  assign s_diow = s[21];
  assign s_cs   = s[20:19];
  assign s_da   = s[18:16];
  assign s_data = s[15:0];

  // Previous synchronized strobe levels for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      dior_q <= 1'b1;
      diow_q <= 1'b1;
    end else begin
      dior_q <= s_dior;
      diow_q <= s_diow;
    end
  end

  assign wr_ev   = diow_q & ~s_diow;
  assign rd_end  = ~dior_q & s_dior;
  assign sel_cmd = (s_cs == CS_CMD);
  assign sel_ctl = (s_cs == CS_CTL) && (s_da == DA_DEVCTL);
  assign lba_inc = lba + 28'd1;

  ide_sector_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (ptr),
    .wdata (buf_wdata),
    .raddr (ptr),
    .rdata (buf_rdata)
  );

  // State and task-file registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 8'd0;
      count <= 8'd1;
      lba   <= 28'd0;
      error <= 8'd0;
      err   <= 1'b0;
      bsy   <= 1'b0;
      drq   <= 1'b0;
      intrq <= 1'b0;
      nien  <= 1'b0;
      srst  <= 1'b0;
      req   <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      count <= count_n;
      lba   <= lba_n;
      error <= error_n;
      err   <= err_n;
      bsy   <= bsy_n;
      drq   <= drq_n;
      intrq <= intrq_n;
      nien  <= nien_n;
      srst  <= srst_n;
      req   <= req_n;
    end
  end

  // Host register writes, command dispatch and sector sequencing.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    count_n   = count;
    lba_n     = lba;
    error_n   = error;
    err_n     = err;
    bsy_n     = bsy;
    drq_n     = drq;
    intrq_n   = intrq;
    nien_n    = nien;
    srst_n    = srst;
    req_n     = req;
    idnf      = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = mem_rdata;

    if (rd_end && sel_cmd && s_da == DA_CMD) intrq_n = 1'b0;

    if (wr_ev && sel_ctl) begin
      nien_n = s_data[DC_NIEN];
      srst_n = s_data[DC_SRST];
    end

    // Features writes are accepted and dropped: no command uses them.
    if (wr_ev && sel_cmd && !bsy) begin
      case (s_da)
        DA_COUNT: count_n       = s_data[7:0];
        DA_LBA0:  lba_n[7:0]    = s_data[7:0];
        DA_LBA1:  lba_n[15:8]   = s_data[7:0];
        DA_LBA2:  lba_n[23:16]  = s_data[7:0];
        DA_DH:    lba_n[27:24]  = s_data[3:0];
        default: ;
      endcase
    end

    unique case (state)
      IDLE: begin
        if (wr_ev && sel_cmd && s_da == DA_CMD && !bsy) begin
          err_n   = 1'b0;
          error_n = 8'd0;
          ptr_n   = 8'd0;
          case (s_data[7:0])
            CMD_READ: begin
              if (!lba_in_range(lba, LBA_BITS)) idnf = 1'b1;
              else begin
                state_n = RD_FETCH;
                bsy_n   = 1'b1;
              end
            end
            CMD_WRITE: begin
              if (!lba_in_range(lba, LBA_BITS)) idnf = 1'b1;
              else begin
                state_n = WR_XFER;
                drq_n   = 1'b1;
              end
            end
            CMD_IDENT, CMD_INITP, CMD_RECAL: intrq_n = 1'b1;
            default: begin
              err_n   = 1'b1;
              error_n = ERR_ABRT;
              intrq_n = 1'b1;
            end
          endcase
        end
      end
      RD_FETCH: begin
        if (!req) req_n = 1'b1;
        else if (mem_done) begin
          req_n  = 1'b0;
          buf_we = 1'b1;
          if (ptr == 8'hFF) begin
            ptr_n   = 8'd0;
            bsy_n   = 1'b0;
            drq_n   = 1'b1;
            intrq_n = 1'b1;
            state_n = RD_XFER;
          end else ptr_n = ptr + 8'd1;
        end
      end
      RD_XFER: begin
        if (rd_end && sel_cmd && s_da == DA_DATA) begin
          if (ptr == 8'hFF) begin
            ptr_n   = 8'd0;
            count_n = count - 8'd1;
            lba_n   = lba_inc;
            drq_n   = 1'b0;
            if (count == 8'd1) state_n = IDLE;
            else if (!lba_in_range(lba_inc, LBA_BITS)) idnf = 1'b1;
            else begin
              bsy_n   = 1'b1;
              state_n = RD_FETCH;
            end
          end else ptr_n = ptr + 8'd1;
        end
      end
      WR_XFER: begin
        if (wr_ev && sel_cmd && s_da == DA_DATA) begin
          buf_we    = 1'b1;
          buf_wdata = s_data;
          if (ptr == 8'hFF) begin
            ptr_n   = 8'd0;
            drq_n   = 1'b0;
            bsy_n   = 1'b1;
            state_n = WR_FLUSH;
          end else ptr_n = ptr + 8'd1;
        end
      end
      WR_FLUSH: begin
        if (!req) req_n = 1'b1;
        else if (mem_done) begin
          req_n = 1'b0;
          if (ptr == 8'hFF) begin
            ptr_n   = 8'd0;
            count_n = count - 8'd1;
            lba_n   = lba_inc;
            intrq_n = 1'b1;
            bsy_n   = 1'b0;
            if (count == 8'd1) state_n = IDLE;
            else if (!lba_in_range(lba_inc, LBA_BITS)) idnf = 1'b1;
            else begin
              drq_n   = 1'b1;
              state_n = WR_XFER;
            end
          end else ptr_n = ptr + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (idnf) begin
      err_n   = 1'b1;
      error_n = ERR_IDNF;
      drq_n   = 1'b0;
      bsy_n   = 1'b0;
      intrq_n = 1'b1;
      state_n = IDLE;
    end

    // Soft reset aborts on the write edge and holds while set.
    if (srst || (wr_ev && sel_ctl && s_data[DC_SRST])) begin
      state_n = IDLE;
      bsy_n   = 1'b0;
      drq_n   = 1'b0;
      req_n   = 1'b0;
      ptr_n   = 8'd0;
    end
  end

  // Status register image.
  always_comb begin
    status          = 8'd0;
    status[ST_BSY]  = bsy;
    status[ST_DRDY] = 1'b1;
    status[ST_DSC]  = 1'b1;
    status[ST_DRQ]  = drq;
    status[ST_ERR]  = err;
  end

  assign rd_sel_cmd = (ide_cs == CS_CMD);
  assign rd_sel_ctl = (ide_cs == CS_CTL) && (ide_da == DA_DEVCTL);

  // Host read mux, decoded straight from the raw bus select.
  always_comb begin
    rd_val = 16'd0;
    unique case (1'b1)
      rd_sel_ctl: rd_val = {8'd0, status};
      rd_sel_cmd: begin
        case (ide_da)
          DA_DATA:  rd_val = (state == RD_XFER) ? buf_rdata : 16'd0;
          DA_ERR:   rd_val = {8'd0, error};
          DA_COUNT: rd_val = {8'd0, count};
          DA_LBA0:  rd_val = {8'd0, lba[7:0]};
          DA_LBA1:  rd_val = {8'd0, lba[15:8]};
          DA_LBA2:  rd_val = {8'd0, lba[23:16]};
          DA_DH:    rd_val = {8'd0, 4'hE, lba[27:24]};
          default:  rd_val = {8'd0, status};
        endcase
      end
      default: rd_val = 16'd0;
    endcase
  end

  assign ide_data_oe  = ~ide_dior & (rd_sel_cmd | rd_sel_ctl) & ~reset;
  assign ide_data_out = ide_data_oe ? rd_val : 16'd0;
  assign ide_intrq    = intrq & ~nien;

  assign mem_rd    = req && (state == RD_FETCH);
  assign mem_wr    = req && (state == WR_FLUSH);
  assign mem_addr  = {lba[LBA_BITS-1:0], ptr};
  assign mem_wdata = mem_wr ? buf_rdata : 16'd0;

endmodule

// File: tb/tb_pdp8_ide_target.sv
// Bench for pdp8_ide_target: host bus tasks, memory model,
// expectation queues drained by a separate monitor.
module tb_pdp8_ide_target;

  localparam int K_DATA  = 0;
  localparam int K_INTRQ = 1;
  localparam int K_MEMRD = 2;
  localparam int K_RDCNT = 3;
  localparam int K_WQ    = 4;
  localparam int K_TMO   = 5;

  localparam logic [1:0] CB = 2'b10;
  localparam logic [1:0] CT = 2'b01;

  typedef struct {
    int          kind;
    string       nm;
    logic [31:0] ex;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ide_dior = 1'b1;
  logic        ide_diow = 1'b1;
  logic [1:0]  ide_cs = 2'b11;
  logic [2:0]  ide_da = 3'd0;
  logic [15:0] ide_data_in = 16'd0;
  logic [15:0] ide_data_out;
  logic        ide_data_oe;
  logic        ide_intrq;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'd0;
  logic        mem_done;
  logic        mdone = 1'b0;
  logic        late_done = 1'b0;
  int          mcnt = 0;

  chk_t        chk_q[$];
  logic [31:0] wq[$];
  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  logic        rd_prev = 1'b0;
  chk_t        it;
  logic [31:0] act;
  logic [31:0] wexp;
  logic [15:0] d;
  int          snap;

  pdp8_ide_target dut (
    .clk          (clk),
    .reset        (reset),
    .ide_dior     (ide_dior),
    .ide_diow     (ide_diow),
    .ide_cs       (ide_cs),
    .ide_da       (ide_da),
    .ide_data_in  (ide_data_in),
    .ide_data_out (ide_data_out),
    .ide_data_oe  (ide_data_oe),
    .ide_intrq    (ide_intrq),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done)
  );

  always #5 clk = ~clk;

  assign mem_done = mdone | late_done;

  // Memory model: word = address, fixed latency, one-cycle done.
  always @(posedge clk) begin
    mdone <= 1'b0;
    if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mdone     <= 1'b1;
        mem_rdata <= mem_addr;
      end
    end else if ((mem_rd || mem_wr) && !mdone) begin
      mcnt <= 2;
    end
  end

  // Monitor: drains expectations and checks memory writes.
  always @(negedge clk) begin
    while (chk_q.size() != 0) begin
      it = chk_q.pop_front();
      case (it.kind)
        K_DATA:  act = {16'd0, ide_data_out};
        K_INTRQ: act = {31'd0, ide_intrq};
        K_MEMRD: act = {31'd0, mem_rd};
        K_RDCNT: act = rd_cnt;
        K_WQ:    act = wq.size();
        default: act = 32'hFFFF_FFFF;
      endcase
      total++;
      if (act !== it.ex) begin
        bad++;
        $display("FAIL %s: got %h want %h", it.nm, act, it.ex);
      end
    end
    if (mem_wr && mem_done) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL memwr_extra: got %h want none",
                 {mem_addr, mem_wdata});
      end else begin
        wexp = wq.pop_front();
        if ({mem_addr, mem_wdata} !== wexp) begin
          bad++;
          $display("FAIL memwr: got %h want %h",
                   {mem_addr, mem_wdata}, wexp);
        end
      end
    end
    if (mem_rd && !rd_prev) rd_cnt++;
    rd_prev = mem_rd;
  end

  task automatic push(input int k, input string nm,
                      input logic [31:0] ex);
    @(posedge clk);
    #1;
    chk_q.push_back('{k, nm, ex});
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic host_wr(input logic [1:0] c, input logic [2:0] a,
                         input logic [15:0] v);
    @(negedge clk);
    ide_cs = c;
    ide_da = a;
    ide_data_in = v;
    repeat (2) @(negedge clk);
    ide_diow = 1'b0;
    repeat (6) @(negedge clk);
    ide_diow = 1'b1;
    repeat (5) @(negedge clk);
    ide_cs = 2'b11;
  endtask

  task automatic host_rd(input logic [1:0] c, input logic [2:0] a,
                         input bit chk, input string nm,
                         input logic [15:0] ex,
                         output logic [15:0] v);
    @(negedge clk);
    ide_cs = c;
    ide_da = a;
    repeat (2) @(negedge clk);
    ide_dior = 1'b0;
    repeat (5) @(negedge clk);
    v = ide_data_out;
    if (chk) push(K_DATA, nm, {16'd0, ex});
    ide_dior = 1'b1;
    repeat (5) @(negedge clk);
    ide_cs = 2'b11;
  endtask

  task automatic rd_chk(input logic [1:0] c, input logic [2:0] a,
                        input string nm, input logic [15:0] ex);
    logic [15:0] v;
    host_rd(c, a, 1'b1, nm, ex, v);
  endtask

  task automatic poll_alt(input logic [7:0] want, input string nm);
    logic [15:0] v;
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      host_rd(CT, 3'd6, 1'b0, "", 16'd0, v);
      if (v[7:0] == want) hit = 1'b1;
    end
    if (!hit) push(K_TMO, nm, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    push(K_INTRQ, "rst_intrq", 32'd0);
    push(K_MEMRD, "rst_memrd", 32'd0);
    rd_chk(CB, 3'd7, "rst_status", 16'h0050);
    rd_chk(CB, 3'd6, "rst_dh", 16'h00E0);
    rd_chk(CB, 3'd2, "rst_count", 16'h0001);

    host_wr(CB, 3'd3, 16'h0005);
    host_wr(CB, 3'd2, 16'h0001);
    host_wr(CB, 3'd7, 16'h0020);
    rd_chk(CT, 3'd6, "rd_bsy", 16'h00D0);
    poll_alt(8'h58, "rd_drq_wait");
    push(K_INTRQ, "rd_intrq", 32'd1);
    rd_chk(CB, 3'd7, "rd_status_drq", 16'h0058);
    for (int i = 0; i < 256; i++)
      rd_chk(CB, 3'd0, "rd_data", 16'h0500 + 16'(i));
    rd_chk(CB, 3'd7, "rd_status_end", 16'h0050);

    for (int i = 0; i < 512; i++)
      wq.push_back({16'h0300 + 16'(i), ~(16'h0300 + 16'(i))});
    host_wr(CB, 3'd3, 16'h0003);
    host_wr(CB, 3'd2, 16'h0002);
    host_wr(CB, 3'd7, 16'h0030);
    poll_alt(8'h58, "wr_drq_wait0");
    push(K_INTRQ, "wr_no_intrq_first", 32'd0);
    for (int i = 0; i < 256; i++)
      host_wr(CB, 3'd0, ~(16'h0300 + 16'(i)));
    poll_alt(8'h58, "wr_drq_wait1");
    push(K_INTRQ, "wr_intrq_flush0", 32'd1);
    rd_chk(CB, 3'd7, "wr_status_mid", 16'h0058);
    for (int i = 256; i < 512; i++)
      host_wr(CB, 3'd0, ~(16'h0300 + 16'(i)));
    poll_alt(8'h50, "wr_done_wait");
    push(K_INTRQ, "wr_intrq_flush1", 32'd1);
    rd_chk(CB, 3'd7, "wr_status_end", 16'h0050);
    rd_chk(CB, 3'd3, "wr_lba_end", 16'h0005);
    rd_chk(CB, 3'd2, "wr_count_end", 16'h0000);
    push(K_WQ, "wr_all_flushed", 32'd0);

    host_wr(CB, 3'd4, 16'h0001);
    host_wr(CB, 3'd3, 16'h0000);
    host_wr(CB, 3'd2, 16'h0001);
    snap = rd_cnt;
    host_wr(CB, 3'd7, 16'h0020);
    rd_chk(CB, 3'd7, "idnf_status", 16'h0051);
    rd_chk(CB, 3'd1, "idnf_error", 16'h0010);
    push(K_RDCNT, "idnf_no_memrd", 32'(snap));
    host_wr(CB, 3'd7, 16'h00FF);
    rd_chk(CB, 3'd1, "abrt_error", 16'h0004);
    rd_chk(CB, 3'd7, "abrt_status", 16'h0051);

    host_wr(CB, 3'd4, 16'h0000);
    host_wr(CB, 3'd3, 16'h0002);
    host_wr(CB, 3'd7, 16'h0020);
    host_wr(CT, 3'd6, 16'h0004);
    push(K_MEMRD, "srst_fetch_memrd", 32'd0);
    rd_chk(CT, 3'd6, "srst_fetch_status", 16'h0050);
    host_wr(CT, 3'd6, 16'h0000);
    rd_chk(CB, 3'd0, "idle_data_zero", 16'h0000);

    host_wr(CB, 3'd2, 16'h0001);
    host_wr(CB, 3'd7, 16'h0020);
    poll_alt(8'h58, "mid_drq_wait");
    rd_chk(CB, 3'd7, "mid_status", 16'h0058);
    for (int i = 0; i < 100; i++)
      rd_chk(CB, 3'd0, "mid_data", 16'h0200 + 16'(i));
    host_wr(CT, 3'd6, 16'h0004);
    push(K_MEMRD, "srst_xfer_memrd", 32'd0);
    rd_chk(CT, 3'd6, "srst_xfer_status", 16'h0050);
    host_wr(CT, 3'd6, 16'h0000);
    snap = rd_cnt;
    @(negedge clk);
    late_done = 1'b1;
    @(negedge clk);
    late_done = 1'b0;
    repeat (4) @(negedge clk);
    push(K_RDCNT, "late_done_memrd", 32'(snap));
    rd_chk(CT, 3'd6, "late_done_status", 16'h0050);
    rd_chk(CB, 3'd0, "late_done_data", 16'h0000);

    host_wr(CT, 3'd6, 16'h0002);
    host_wr(CB, 3'd7, 16'h0010);
    push(K_INTRQ, "nien_masked", 32'd0);
    rd_chk(CT, 3'd6, "nien_alt", 16'h0050);
    host_wr(CT, 3'd6, 16'h0000);
    push(K_INTRQ, "nien_pending", 32'd1);
    rd_chk(CB, 3'd7, "nien_status", 16'h0050);
    push(K_INTRQ, "nien_cleared", 32'd0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
